// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback path: comwbInfo_t payload and arbiter defaults.
package wb_arbiter_pkg;

   localparam int unsigned ROB_IDX_W      = 6;
   localparam int unsigned IROB_IDX_W     = 4;
   localparam int unsigned PRD_IDX_W      = 6;
   localparam int unsigned XLEN           = 32;
   localparam int unsigned DEFAULT_NUM_FU = 4;
   localparam int unsigned DEFAULT_NUM_WB = 2;

   typedef struct packed {
      logic [ROB_IDX_W-1:0]  rob_idx;
      logic [IROB_IDX_W-1:0] irob_idx;
      logic                  use_imm;
      logic                  rd_wen;
      logic [PRD_IDX_W-1:0]  iprd_idx;
      logic [XLEN-1:0]       result;
   } comwbInfo_t;

   // Index width for n sources; at least one bit so a single source still has a pointer.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Round-robin first-N selector: grants up to NUM_WB requesters starting at rr_ptr.
module wb_rr_select
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = DEFAULT_NUM_FU,
   parameter int unsigned NUM_WB = DEFAULT_NUM_WB,
   parameter int unsigned PTR_W  = ptr_width(NUM_FU)
) (
   input  logic [NUM_FU-1:0] req,
   input  logic [PTR_W-1:0]  rr_ptr,
   output logic [NUM_FU-1:0] grant,
   output logic [PTR_W-1:0]  slot_idx [NUM_WB],
   output logic [NUM_WB-1:0] slot_vld,
   output logic [PTR_W-1:0]  last_idx
);

   // Scan from rr_ptr with wrap; the k-th hit lands in slot k.
   always_comb begin
      int unsigned     cnt;
      logic [PTR_W-1:0] idx;
      grant    = '0;
      slot_vld = '0;
      last_idx = rr_ptr;
      cnt      = 0;
      idx      = '0;
      for (int unsigned k = 0; k < NUM_WB; k++) slot_idx[k] = '0;
      for (int unsigned off = 0; off < NUM_FU; off++) begin
         idx = PTR_W'((32'(rr_ptr) + off) % NUM_FU);
         if (req[idx] && (cnt < NUM_WB)) begin
            grant[idx] = 1'b1;
            for (int unsigned k = 0; k < NUM_WB; k++) begin
               if (cnt == k) begin
                  slot_idx[k] = idx;
                  slot_vld[k] = 1'b1;
               end
            end
            last_idx = idx;
            cnt      = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_FU result sources share NUM_WB registered writeback slots.
// Optional WB_ARB_PERF_EN adds o_conflict_cnt, counting cycles in which any FU is stalled.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU = DEFAULT_NUM_FU,
   parameter int unsigned NUM_WB = DEFAULT_NUM_WB
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_FU-1:0] i_fu_finished,
   input  comwbInfo_t        i_comwbInfo [NUM_FU],
   output logic [NUM_FU-1:0] o_wb_stall,
   input  logic              i_wb_block,
   output logic [NUM_WB-1:0] o_wb_vld,
   output comwbInfo_t        o_wbInfo [NUM_WB]
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]       o_conflict_cnt
`endif
);

   localparam int unsigned PTR_W = ptr_width(NUM_FU);

   logic [PTR_W-1:0]  rr_ptr;
   logic [NUM_FU-1:0] req;
   logic [NUM_FU-1:0] grant;
   logic [PTR_W-1:0]  slot_idx [NUM_WB];
   logic [NUM_WB-1:0] slot_vld;
   logic [PTR_W-1:0]  last_idx;

   // No requests compete while in reset or while downstream is blocked.
   always_comb begin
      req        = (rst && !i_wb_block) ? i_fu_finished : '0;
      o_wb_stall = rst ? (i_fu_finished & ~grant) : '0;
   end

   wb_rr_select #(
      .NUM_FU (NUM_FU),
      .NUM_WB (NUM_WB),
      .PTR_W  (PTR_W)
   ) u_select (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .grant    (grant),
      .slot_idx (slot_idx),
      .slot_vld (slot_vld),
      .last_idx (last_idx)
   );

   // Slot valids and round-robin pointer; pointer moves past the last granted FU.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_wb_vld <= '0;
         rr_ptr   <= '0;
      end else begin
         o_wb_vld <= slot_vld;
         if (|slot_vld) begin
            rr_ptr <= (32'(last_idx) == NUM_FU - 1) ? '0 : last_idx + PTR_W'(1);
         end
      end
   end

   // Payload capture; invalid slots keep stale data.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
         if (slot_vld[k]) o_wbInfo[k] <= i_comwbInfo[slot_idx[k]];
      end
   end

`ifdef WB_ARB_PERF_EN
   // Conflict counter: cycles with at least one stalled FU, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!rst)             o_conflict_cnt <= '0;
      else if (|o_wb_stall) o_conflict_cnt <= o_conflict_cnt + 32'd1;
   end
`endif

endmodule
